// File: rtl/mmu_arbiter.sv
// mmu_arbiter: two-port (instruction fetch / load-store) arbiter in front of an MMU.
// One transaction in flight at a time. Requests are sampled only in IDLE.
// Contention is resolved round-robin on the last served port.
// A wait counter bounds each ACCESS phase and reports a timeout as err.
// Every output is registered.
module mmu_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic              p0_err,
  output logic              p1_err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] virtual_addr,
  output logic [DATA_W-1:0] data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] data_out,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Last wait-count value before the timeout fires, giving TIMEOUT ACCESS cycles in total
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t      state;
  logic        last_ptr;
  logic        cur;
  logic        cur_we;
  logic [7:0]  wait_cnt;

  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Winner selection: a lone requester wins; on contention the port not served last wins
  always_comb begin
    sel = p1_req;
    if (p0_req && p1_req) sel = ~last_ptr;
    sel_we    = sel ? p1_we    : p0_we;
    sel_addr  = sel ? p1_addr  : p0_addr;
    sel_wdata = sel ? p1_wdata : p0_wdata;
  end

  // Arbiter FSM with registered handshake pulses and MMU strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_ptr     <= 1'b0;
      cur          <= 1'b0;
      cur_we       <= 1'b0;
      wait_cnt     <= '0;
      p0_gnt       <= 1'b0;
      p1_gnt       <= 1'b0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_err       <= 1'b0;
      p1_err       <= 1'b0;
      rdata        <= '0;
      virtual_addr <= '0;
      data_in      <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
    end else begin
      p0_gnt <= 1'b0;
      p1_gnt <= 1'b0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p0_err <= 1'b0;
      p1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            cur          <= sel;
            cur_we       <= sel_we;
            virtual_addr <= sel_addr;
            data_in      <= sel_wdata;
            mem_read     <= ~sel_we;
            mem_write    <= sel_we;
            p0_gnt       <= ~sel;
            p1_gnt       <= sel;
            wait_cnt     <= '0;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          // Ack/err are registered on leaving ACCESS so they appear exactly in the RESP cycle;
          // mem_ready is checked before the limit so a same-cycle ready wins over the timeout
          if (mem_ready) begin
            if (!cur_we) rdata <= data_out;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            p0_ack    <= ~cur;
            p1_ack    <= cur;
            state     <= RESP;
          end else if (wait_cnt == LIMIT) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            p0_ack    <= ~cur;
            p1_ack    <= cur;
            p0_err    <= ~cur;
            p1_err    <= cur;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          last_ptr <= cur;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed testbench for mmu_arbiter: each scenario is a task with inline checks.
// Inputs are driven and outputs sampled 1 time unit after the rising clock edge.
module tb_mmu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p1_req, p0_we, p1_we;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_ack, p1_ack, p0_err, p1_err;
  logic [31:0] rdata, virtual_addr, data_in, data_out;
  logic        mem_read, mem_write, mem_ready;

  int unsigned tests = 0;
  int unsigned fails = 0;

  mmu_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_ack(p0_ack), .p1_ack(p1_ack),
    .p0_err(p0_err), .p1_err(p1_err), .rdata(rdata),
    .virtual_addr(virtual_addr), .data_in(data_in),
    .mem_read(mem_read), .mem_write(mem_write),
    .data_out(data_out), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
    data_out = 0; mem_ready = 0;
    #3;
    tests++;
    if ({p0_gnt, p1_gnt, p0_ack, p1_ack, p0_err, p1_err, mem_read, mem_write} !== 8'h00) begin
      fails++; $display("FAIL reset_ctl: got %b want 00000000",
        {p0_gnt, p1_gnt, p0_ack, p1_ack, p0_err, p1_err, mem_read, mem_write});
    end
    tests++;
    if (rdata !== 32'd0 || virtual_addr !== 32'd0 || data_in !== 32'd0) begin
      fails++; $display("FAIL reset_data: got rdata=%h va=%h din=%h want 0", rdata, virtual_addr, data_in);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    p1_req = 1; p1_we = 1; p1_addr = 32'd10; p1_wdata = 32'd42; mem_ready = 0;
    tick();
    tests++;
    if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin
      fails++; $display("FAIL wr_gnt: got p0=%b p1=%b want p0=0 p1=1", p0_gnt, p1_gnt);
    end
    tests++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || virtual_addr !== 32'd10 || data_in !== 32'd42) begin
      fails++; $display("FAIL wr_bus: got w=%b r=%b va=%0d din=%0d want 1 0 10 42",
        mem_write, mem_read, virtual_addr, data_in);
    end
    p1_req = 0;
    tick();
    tests++;
    if (p1_gnt !== 1'b0 || mem_write !== 1'b1 || p1_ack !== 1'b0) begin
      fails++; $display("FAIL wr_access2: got gnt=%b w=%b ack=%b want 0 1 0", p1_gnt, mem_write, p1_ack);
    end
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tests++;
    if (p1_ack !== 1'b1 || p1_err !== 1'b0 || p0_ack !== 1'b0 || mem_write !== 1'b0) begin
      fails++; $display("FAIL wr_ack: got ack=%b err=%b p0ack=%b w=%b want 1 0 0 0",
        p1_ack, p1_err, p0_ack, mem_write);
    end
    tick();
    tests++;
    if (p1_ack !== 1'b0) begin
      fails++; $display("FAIL wr_ack_pulse: got %b want 0", p1_ack);
    end
  endtask

  task automatic test_read();
    int unsigned n = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'd20; data_out = 32'h55; mem_ready = 0;
    tick();
    p0_req = 0;
    tests++;
    if (p0_gnt !== 1'b1 || virtual_addr !== 32'd20) begin
      fails++; $display("FAIL rd_gnt: got gnt=%b va=%0d want 1 20", p0_gnt, virtual_addr);
    end
    for (int i = 0; i < 4; i++) begin
      if (mem_read === 1'b1 && mem_write === 1'b0) n++;
      if (i == 3) begin mem_ready = 1; data_out = 32'd84; end
      tick();
    end
    mem_ready = 0; data_out = 32'h55;
    tests++;
    if (n !== 4) begin
      fails++; $display("FAIL rd_strobe_cycles: got %0d want 4", n);
    end
    tests++;
    if (p0_ack !== 1'b1 || p0_err !== 1'b0 || rdata !== 32'd84 || mem_read !== 1'b0) begin
      fails++; $display("FAIL rd_ack: got ack=%b err=%b rdata=%0d r=%b want 1 0 84 0",
        p0_ack, p0_err, rdata, mem_read);
    end
    tick();
  endtask

  task automatic test_timeout();
    int unsigned n = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'd30; data_out = 32'hDEAD; mem_ready = 0;
    tick();
    p0_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (p0_ack === 1'b1) break;
      if (mem_read === 1'b1) n++;
      tick();
    end
    tests++;
    if (n !== 16) begin
      fails++; $display("FAIL to_cycles: got %0d want 16", n);
    end
    tests++;
    if (p0_ack !== 1'b1 || p0_err !== 1'b1 || rdata !== 32'd84 || mem_read !== 1'b0) begin
      fails++; $display("FAIL to_ack: got ack=%b err=%b rdata=%0d r=%b want 1 1 84 0",
        p0_ack, p0_err, rdata, mem_read);
    end
    tick();
    p1_req = 1; p1_we = 0; p1_addr = 32'd40; data_out = 32'h77; mem_ready = 1;
    tick();
    p1_req = 0;
    tests++;
    if (p1_gnt !== 1'b1) begin
      fails++; $display("FAIL to_next_gnt: got %b want 1", p1_gnt);
    end
    tick();
    mem_ready = 0;
    tests++;
    if (p1_ack !== 1'b1 || p1_err !== 1'b0 || rdata !== 32'h77) begin
      fails++; $display("FAIL to_next_ack: got ack=%b err=%b rdata=%h want 1 0 77", p1_ack, p1_err, rdata);
    end
    tick();
  endtask

  task automatic test_idle_ready();
    int unsigned bad = 0;
    data_out = 32'h99;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1;
      tick();
      if (p0_ack || p1_ack || p0_gnt || p1_gnt || mem_read || mem_write || rdata !== 32'h77) bad++;
    end
    mem_ready = 0;
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL idle_ready: got %0d bad cycles want 0", bad);
    end
    p0_req = 1; p0_we = 1; p0_addr = 32'd50; p0_wdata = 32'd5;
    tick();
    p0_req = 0;
    tests++;
    if (p0_gnt !== 1'b1 || mem_write !== 1'b1 || data_in !== 32'd5) begin
      fails++; $display("FAIL idle_then_gnt: got gnt=%b w=%b din=%0d want 1 1 5", p0_gnt, mem_write, data_in);
    end
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tests++;
    if (p0_ack !== 1'b1 || rdata !== 32'h77) begin
      fails++; $display("FAIL idle_wr_ack: got ack=%b rdata=%h want 1 77", p0_ack, rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int unsigned acks = 0;
    p1_req = 1; p1_we = 0; p1_addr = 32'd60; mem_ready = 0;
    tick();
    p1_req = 0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || virtual_addr !== 32'd0 || p1_gnt !== 1'b0) begin
      fails++; $display("FAIL rst_mid: got r=%b w=%b va=%0d gnt=%b want 0 0 0 0",
        mem_read, mem_write, virtual_addr, p1_gnt);
    end
    tick();
    rst_n = 1'b1;
    mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (p0_ack || p1_ack) acks++;
    end
    mem_ready = 0;
    tests++;
    if (acks !== 0) begin
      fails++; $display("FAIL rst_no_ack: got %0d acks want 0", acks);
    end
    p0_req = 1; p0_we = 0; p0_addr = 32'd70; data_out = 32'd123;
    tick();
    p0_req = 0;
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tests++;
    if (p0_ack !== 1'b1 || p0_err !== 1'b0 || rdata !== 32'd123) begin
      fails++; $display("FAIL rst_recover: got ack=%b err=%b rdata=%0d want 1 0 123", p0_ack, p0_err, rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int unsigned ng = 0;
    int unsigned both = 0;
    int unsigned gap_bad = 0;
    int unsigned last_g = 0;
    logic [3:0] order = '0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    p0_req = 1; p1_req = 1; p0_we = 0; p1_we = 0; mem_ready = 1;
    for (int unsigned c = 1; c <= 30 && ng < 4; c++) begin
      tick();
      if ((p0_gnt && p1_gnt) || (p0_ack && p1_ack) || (mem_read && mem_write)) both++;
      if (p0_gnt || p1_gnt) begin
        order[ng] = p1_gnt;
        if (ng != 0 && (c - last_g) < 3) gap_bad++;
        last_g = c;
        ng++;
      end
    end
    p0_req = 0; p1_req = 0; mem_ready = 0;
    tests++;
    if (ng !== 4 || order !== 4'b0101) begin
      fails++; $display("FAIL alt_order: got %0d grants order(p1 bits)=%b want 4 0101", ng, order);
    end
    tests++;
    if (both !== 0 || gap_bad !== 0) begin
      fails++; $display("FAIL alt_exclusive: got both=%0d short_gaps=%0d want 0 0", both, gap_bad);
    end
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_idle_ready();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmu_arbiter.md
MMU_ARBITER -- requirements
Module: mmu_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 16, max ACCESS cycles waiting for mem_ready (range 2..255).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 p0_req, p1_req  input  1 each  access request; port 0 = instruction fetch, port 1 = load/store.
REQ-005 p0_we, p1_we  input  1 each  1 = write, 0 = read.
REQ-006 p0_addr, p1_addr  input  ADDR_W each  virtual address.
REQ-007 p0_wdata, p1_wdata  input  DATA_W each  write data.
REQ-008 p0_gnt, p1_gnt  output  1 each  one-cycle pulse: request accepted.
REQ-009 p0_ack, p1_ack  output  1 each  one-cycle pulse: transaction complete.
REQ-010 p0_err, p1_err  output  1 each  valid with ack; 1 = timeout.
REQ-011 rdata  output  DATA_W  read data, shared, valid in ack cycle.
REQ-012 virtual_addr  output  ADDR_W  to MMU.
REQ-013 data_in  output  DATA_W  to MMU.
REQ-014 mem_read, mem_write  output  1 each  to MMU strobes.
REQ-015 data_out  input  DATA_W  from MMU.
REQ-016 mem_ready  input  1  from MMU.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; all outputs registered.
REQ-018 IDLE: if no req, stay; else select winner, latch its we/addr/wdata, go ACCESS.
REQ-019 Arbitration: one requester -> it wins; both -> port not served last (last_ptr); last_ptr = 0 after reset, so first contention goes to port 1.
REQ-020 req sampled only in IDLE; requester holds req until gnt and deasserts it in gnt cycle; req high in IDLE = new request.
REQ-021 ACCESS: winner's gnt high first ACCESS cycle only; mem_read = !we, mem_write = we for every ACCESS cycle; virtual_addr/data_in hold latched values.
REQ-022 mem_ready sampled each ACCESS edge; when 1: rdata <= data_out (reads only; writes leave rdata unchanged), go RESP, strobes low next cycle.
REQ-023 Wait counter cleared on ACCESS entry, +1 per ACCESS cycle without mem_ready; at TIMEOUT ACCESS cycles without ready -> RESP with err; mem_ready in same cycle as limit wins (no err).
REQ-024 RESP: winner's ack high exactly one cycle, err as determined, strobes low, last_ptr <= winner, go IDLE.
REQ-025 Latency: req at IDLE edge N -> gnt cycle N+1; mem_ready at cycle N+1+k -> ack cycle N+2+k; min issue interval 3 cycles.
REQ-026 mem_read and mem_write never both 1; gnt/ack never to both ports in same cycle.
REQ-027 mem_ready outside ACCESS ignored.

Reset
REQ-028 rst_n low immediately (async): state IDLE, last_ptr 0, counter 0, all gnt/ack/err 0, mem_read/mem_write 0, virtual_addr/data_in/rdata 0.
REQ-029 Reset during ACCESS/RESP drops in-flight transaction: no ack issued; operation restarts from IDLE on first edge after rst_n rises.

Verification
REQ-030 P1 write addr 10 data 42, mem_ready 1 cycle later -> p1_gnt cycle 1, mem_write=1 addr 10 data_in 42, p1_ack cycle 3, p1_err 0.
REQ-031 P0 read addr 20, MMU returns 84 after 3 wait cycles -> mem_read held 4 cycles, p0_ack with rdata=84, p0_err 0.
REQ-032 Both req continuously after reset -> grants p1,p0,p1,p0 alternating, never both, each transaction >= 3 cycles.
REQ-033 mem_ready held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then ack+err on winner, rdata unchanged, arbiter returns IDLE and serves next req.
REQ-034 rst_n low in mid-ACCESS -> mem_read/mem_write 0 same cycle, no ack; after release new request completes normally.
REQ-035 mem_ready pulses in IDLE -> no ack, no state change.
